gray_ptr_sync_bank: RTL and testbench



---
 rtl/cdc_pkg.sv | 34 +++
 rtl/gray_ptr_sync_ch.sv | 123 ++++++++++++
 rtl/gray_ptr_sync_bank.sv | 68 ++++++
 tb/tb_gray_ptr_sync_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared CDC helpers: gray-to-binary conversion, multi-bit-change detection
// and the priming window length used by the pointer synchronizers.
package cdc_pkg;

  // Widest pointer the helpers handle; callers zero-extend narrower pointers.
  localparam int MAX_P = 32;

  // Cycles after reset release before the first trusted update: the sync
  // chain must fill (num_stages) plus one registered update.
  function automatic int prime_cycles(input int num_stages);
    return num_stages + 1;
  endfunction

  // Gray to binary: b[i] = XOR of g[MSB:i]. Zero-extended upper bits are
  // zero, so the result is correct for any pointer width up to MAX_P.
  function automatic logic [MAX_P-1:0] g2b(input logic [MAX_P-1:0] g);
    logic [MAX_P-1:0] b;
    b = {MAX_P{1'b0}};
    b[MAX_P-1] = g[MAX_P-1];
    for (int i = MAX_P - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit
  // leaves something behind).
  function automatic logic popcount_gt1(input logic [MAX_P-1:0] x);
    logic [MAX_P-1:0] low_cleared;
    low_cleared = x & (x - {{(MAX_P-1){1'b0}}, 1'b1});
    return (low_cleared != {MAX_P{1'b0}});
  endfunction

endpackage

// File: rtl/gray_ptr_sync_ch.sv
// One gray pointer synchronizer channel: sync chain, registered binary
// pointer, advance count/strobe and sticky multi-bit-change error.
module gray_ptr_sync_ch
  import cdc_pkg::*;
#(
  parameter int P_SIZE     = 4,
  parameter int NUM_STAGES = 2,
  parameter int ERR_CHK    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [P_SIZE-1:0] i_gray_async,
  input  logic              i_en,
  input  logic              i_err_clr,
  input  logic              i_primed,
  output logic [P_SIZE-1:0] o_gray_sync,
  output logic [P_SIZE-1:0] o_bin,
  output logic [P_SIZE-1:0] o_adv,
  output logic              o_adv_vld,
  output logic              o_gray_err
);

  logic [NUM_STAGES-1:0][P_SIZE-1:0] sync_r;
  logic [P_SIZE-1:0] g_q_r;
  logic [P_SIZE-1:0] bin_r;
  logic [P_SIZE-1:0] adv_r;
  logic              adv_vld_r;
  logic              err_r;
  logic              en_d_r;

  logic [P_SIZE-1:0] gs_s;
  logic [P_SIZE-1:0] bin_new_s;
  logic [P_SIZE-1:0] diff_s;
  logic              ch_prime_s;
  logic              check_s;
  logic              err_set_s;
  logic [P_SIZE-1:0] g_q_nxt_s;
  logic [P_SIZE-1:0] bin_nxt_s;
  logic [P_SIZE-1:0] adv_nxt_s;
  logic              adv_vld_nxt_s;
  logic              err_nxt_s;

  assign gs_s       = sync_r[NUM_STAGES-1];
  assign bin_new_s  = P_SIZE'(g2b(MAX_P'(gs_s)));
  assign diff_s     = bin_new_s - bin_r;
  // First enabled cycle after the enable rises only re-baselines the channel.
  assign ch_prime_s = i_en & ~en_d_r;
  assign check_s    = i_en & i_primed & ~ch_prime_s;
  assign err_set_s  = (ERR_CHK != 0) && check_s && popcount_gt1(MAX_P'(gs_s ^ g_q_r));

  // Synchronizer chain, free-running regardless of the channel enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_r <= {(NUM_STAGES*P_SIZE){1'b0}};
    end else begin
      sync_r[0] <= i_gray_async;
      for (int s = 1; s < NUM_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Next-state for the update stage and the sticky error flag.
  always_comb begin
    g_q_nxt_s     = g_q_r;
    bin_nxt_s     = bin_r;
    adv_nxt_s     = adv_r;
    adv_vld_nxt_s = 1'b0;
    err_nxt_s     = err_r;

    if (i_en) begin
      g_q_nxt_s = gs_s;
      bin_nxt_s = bin_new_s;
      if (check_s) begin
        adv_nxt_s     = diff_s;
        adv_vld_nxt_s = (diff_s != {P_SIZE{1'b0}});
      end else begin
        adv_nxt_s     = {P_SIZE{1'b0}};
        adv_vld_nxt_s = 1'b0;
      end
    end else begin
      g_q_nxt_s     = g_q_r;
      bin_nxt_s     = bin_r;
      adv_nxt_s     = adv_r;
      adv_vld_nxt_s = 1'b0;
    end

    // A new violation outranks a clear in the same cycle.
    if (err_set_s) begin
      err_nxt_s = 1'b1;
    end else if (i_err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Update-stage registers and enable edge detector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      g_q_r     <= {P_SIZE{1'b0}};
      bin_r     <= {P_SIZE{1'b0}};
      adv_r     <= {P_SIZE{1'b0}};
      adv_vld_r <= 1'b0;
      err_r     <= 1'b0;
      en_d_r    <= 1'b0;
    end else begin
      g_q_r     <= g_q_nxt_s;
      bin_r     <= bin_nxt_s;
      adv_r     <= adv_nxt_s;
      adv_vld_r <= adv_vld_nxt_s;
      err_r     <= err_nxt_s;
      en_d_r    <= i_en;
    end
  end

  assign o_gray_sync = gs_s;
  assign o_bin       = bin_r;
  assign o_adv       = adv_r;
  assign o_adv_vld   = adv_vld_r;
  assign o_gray_err  = err_r;

endmodule

// File: rtl/gray_ptr_sync_bank.sv
// Bank of N_CH gray pointer synchronizers sharing one destination clock and
// one post-reset priming counter.
module gray_ptr_sync_bank
  import cdc_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int P_SIZE     = 4,
  parameter int NUM_STAGES = 2,
  parameter int ERR_CHK    = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_CH*P_SIZE-1:0] i_gray_async,
  input  logic [N_CH-1:0]        i_ch_en,
  input  logic [N_CH-1:0]        i_err_clr,
  output logic [N_CH*P_SIZE-1:0] o_gray_sync,
  output logic [N_CH*P_SIZE-1:0] o_bin,
  output logic [N_CH*P_SIZE-1:0] o_adv,
  output logic [N_CH-1:0]        o_adv_vld,
  output logic [N_CH-1:0]        o_gray_err,
  output logic                   o_primed
);

  localparam int PRIME_CYCLES = prime_cycles(NUM_STAGES);
  localparam int CNT_W        = $clog2(PRIME_CYCLES);

  logic [CNT_W-1:0] prime_cnt_r;
  logic             primed_r;

  // Count PRIME_CYCLES edges after reset release, then stay primed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prime_cnt_r <= {CNT_W{1'b0}};
      primed_r    <= 1'b0;
    end else if (!primed_r) begin
      if (prime_cnt_r == CNT_W'(PRIME_CYCLES - 1)) begin
        primed_r <= 1'b1;
      end else begin
        prime_cnt_r <= prime_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      primed_r <= 1'b1;
    end
  end

  assign o_primed = primed_r;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    gray_ptr_sync_ch #(
      .P_SIZE     (P_SIZE),
      .NUM_STAGES (NUM_STAGES),
      .ERR_CHK    (ERR_CHK)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_gray_async (i_gray_async[c*P_SIZE +: P_SIZE]),
      .i_en         (i_ch_en[c]),
      .i_err_clr    (i_err_clr[c]),
      .i_primed     (primed_r),
      .o_gray_sync  (o_gray_sync[c*P_SIZE +: P_SIZE]),
      .o_bin        (o_bin[c*P_SIZE +: P_SIZE]),
      .o_adv        (o_adv[c*P_SIZE +: P_SIZE]),
      .o_adv_vld    (o_adv_vld[c]),
      .o_gray_err   (o_gray_err[c])
    );
  end

endmodule

// File: tb/tb_gray_ptr_sync_bank.sv
// Directed bench for gray_ptr_sync_bank (N_CH=2, P_SIZE=4, NUM_STAGES=2).
module tb_gray_ptr_sync_bank;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_gray_async;
  logic [1:0] i_ch_en;
  logic [1:0] i_err_clr;
  logic [7:0] o_gray_sync;
  logic [7:0] o_bin;
  logic [7:0] o_adv;
  logic [1:0] o_adv_vld;
  logic [1:0] o_gray_err;
  logic       o_primed;

  int total = 0;
  int bad   = 0;

  gray_ptr_sync_bank #(
    .N_CH(2), .P_SIZE(4), .NUM_STAGES(2), .ERR_CHK(1)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_gray_async (i_gray_async),
    .i_ch_en      (i_ch_en),
    .i_err_clr    (i_err_clr),
    .o_gray_sync  (o_gray_sync),
    .o_bin        (o_bin),
    .o_adv        (o_adv),
    .o_adv_vld    (o_adv_vld),
    .o_gray_err   (o_gray_err),
    .o_primed     (o_primed)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_gray(input int ch, input logic [3:0] g);
    i_gray_async[ch*4 +: 4] = g;
  endtask

  function automatic logic [3:0] bin_of(input int ch);
    return o_bin[ch*4 +: 4];
  endfunction

  function automatic logic [3:0] adv_of(input int ch);
    return o_adv[ch*4 +: 4];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gsync"}, {24'd0, o_gray_sync}, 32'd0);
    chk({tag, "_bin"},   {24'd0, o_bin},       32'd0);
    chk({tag, "_adv"},   {24'd0, o_adv},       32'd0);
    chk({tag, "_vld"},   {30'd0, o_adv_vld},   32'd0);
    chk({tag, "_err"},   {30'd0, o_gray_err},  32'd0);
    chk({tag, "_primed"},{31'd0, o_primed},    32'd0);
  endtask

  // One legal single-bit step on a channel; result lands 3 edges later.
  task automatic step(input int ch, input logic [3:0] g, input logic [3:0] prev_bin,
                      input logic [3:0] exp_bin, input string tag);
    set_gray(ch, g);
    @(negedge i_clk);
    @(negedge i_clk);
    chk({tag, "_early_bin"}, {28'd0, bin_of(ch)}, {28'd0, prev_bin});
    chk({tag, "_early_vld"}, {31'd0, o_adv_vld[ch]}, 32'd0);
    @(negedge i_clk);
    chk({tag, "_bin"}, {28'd0, bin_of(ch)}, {28'd0, exp_bin});
    chk({tag, "_adv"}, {28'd0, adv_of(ch)}, 32'd1);
    chk({tag, "_vld"}, {31'd0, o_adv_vld[ch]}, 32'd1);
    chk({tag, "_err"}, {30'd0, o_gray_err}, 32'd0);
    @(negedge i_clk);
    chk({tag, "_vld_off"}, {31'd0, o_adv_vld[ch]}, 32'd0);
  endtask

  initial begin
    i_rst        = 1'b1;
    i_gray_async = 8'h06;
    i_ch_en      = 2'b11;
    i_err_clr    = 2'b00;

    // Reset and priming
    repeat (3) @(negedge i_clk);
    chk_all_zero("rst");
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("prime_c1", {31'd0, o_primed}, 32'd0);
    @(negedge i_clk);
    chk("prime_c2", {31'd0, o_primed}, 32'd0);
    chk("prime_gsync", {24'd0, o_gray_sync}, 32'h06);
    @(negedge i_clk);
    chk("prime_c3", {31'd0, o_primed}, 32'd1);
    chk("prime_bin", {24'd0, o_bin}, 32'h04);
    chk("prime_adv", {24'd0, o_adv}, 32'd0);
    chk("prime_vld", {30'd0, o_adv_vld}, 32'd0);
    chk("prime_err", {30'd0, o_gray_err}, 32'd0);
    @(negedge i_clk);
    chk("prime_after_vld", {30'd0, o_adv_vld}, 32'd0);

    // Move channel 0 to gray 0 while disabled
    i_ch_en = 2'b10;
    set_gray(0, 4'b0000);
    repeat (4) @(negedge i_clk);
    chk("zero_hold_bin", {28'd0, bin_of(0)}, 32'd4);
    i_ch_en = 2'b11;
    @(negedge i_clk);
    chk("zero_reen_bin", {28'd0, bin_of(0)}, 32'd0);
    chk("zero_reen_adv", {28'd0, adv_of(0)}, 32'd0);
    chk("zero_reen_vld", {30'd0, o_adv_vld}, 32'd0);
    chk("zero_reen_err", {30'd0, o_gray_err}, 32'd0);

    // Single steps 0 -> 1 -> 3 -> 2
    step(0, 4'b0001, 4'd0, 4'd1, "s1");
    step(0, 4'b0011, 4'd1, 4'd2, "s2");
    step(0, 4'b0010, 4'd2, 4'd3, "s3");

    // Jump to bin 14 while disabled, then wrap 14 -> 15 -> 0
    i_ch_en = 2'b10;
    set_gray(0, 4'b1001);
    repeat (4) @(negedge i_clk);
    chk("j14_hold_bin", {28'd0, bin_of(0)}, 32'd3);
    i_ch_en = 2'b11;
    @(negedge i_clk);
    chk("j14_bin", {28'd0, bin_of(0)}, 32'd14);
    chk("j14_adv", {28'd0, adv_of(0)}, 32'd0);
    chk("j14_vld", {30'd0, o_adv_vld}, 32'd0);
    chk("j14_err", {30'd0, o_gray_err}, 32'd0);
    step(0, 4'b1000, 4'd14, 4'd15, "w15");
    step(0, 4'b0000, 4'd15, 4'd0, "w0");

    // Enable gating: 0 -> 1 -> 3 -> 2 while disabled
    i_ch_en = 2'b10;
    set_gray(0, 4'b0001);
    repeat (4) @(negedge i_clk);
    chk("gate_hold1", {28'd0, bin_of(0)}, 32'd0);
    set_gray(0, 4'b0011);
    repeat (4) @(negedge i_clk);
    chk("gate_hold2", {28'd0, bin_of(0)}, 32'd0);
    set_gray(0, 4'b0010);
    repeat (4) @(negedge i_clk);
    chk("gate_hold3", {28'd0, bin_of(0)}, 32'd0);
    chk("gate_hold_vld", {30'd0, o_adv_vld}, 32'd0);
    i_ch_en = 2'b11;
    @(negedge i_clk);
    chk("gate_reen_bin", {28'd0, bin_of(0)}, 32'd3);
    chk("gate_reen_adv", {28'd0, adv_of(0)}, 32'd0);
    chk("gate_reen_vld", {30'd0, o_adv_vld}, 32'd0);
    chk("gate_reen_err", {30'd0, o_gray_err}, 32'd0);

    // Gray violation on channel 1: 0000 -> 0101
    set_gray(1, 4'b0101);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("viol_early_err", {30'd0, o_gray_err}, 32'd0);
    @(negedge i_clk);
    chk("viol_err", {30'd0, o_gray_err}, 32'h2);
    chk("viol_bin1", {28'd0, bin_of(1)}, 32'd6);
    repeat (3) @(negedge i_clk);
    chk("viol_sticky", {30'd0, o_gray_err}, 32'h2);

    // Second violation coincident with clear: set wins
    set_gray(1, 4'b0000);
    @(negedge i_clk);
    @(negedge i_clk);
    i_err_clr = 2'b10;
    @(negedge i_clk);
    chk("set_wins", {30'd0, o_gray_err}, 32'h2);
    i_err_clr = 2'b00;
    @(negedge i_clk);
    chk("set_wins_hold", {30'd0, o_gray_err}, 32'h2);

    // Clear alone
    i_err_clr = 2'b10;
    @(negedge i_clk);
    chk("clr_alone", {30'd0, o_gray_err}, 32'd0);
    i_err_clr = 2'b00;
    @(negedge i_clk);
    chk("clr_stays", {30'd0, o_gray_err}, 32'd0);

    // Asynchronous reset while a strobe is active
    set_gray(0, 4'b0110);
    repeat (3) @(negedge i_clk);
    chk("pre_rst_vld", {30'd0, o_adv_vld}, 32'h1);
    chk("pre_rst_bin", {28'd0, bin_of(0)}, 32'd4);
    #2;
    i_rst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("reprime_c1", {31'd0, o_primed}, 32'd0);
    @(negedge i_clk);
    chk("reprime_c2", {31'd0, o_primed}, 32'd0);
    @(negedge i_clk);
    chk("reprime_c3", {31'd0, o_primed}, 32'd1);
    chk("reprime_bin", {24'd0, o_bin}, 32'h04);
    chk("reprime_vld", {30'd0, o_adv_vld}, 32'd0);
    chk("reprime_err", {30'd0, o_gray_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
